// File: rtl/iir_pkg.sv
// Shared types and constants for the biquad cascade sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package iir_pkg;

  localparam int NDINT    = 3;   // integer bits of a data word, sign included
  localparam int NDFRAC   = 22;  // fractional bits of a data word
  localparam int TMAX_DEF = 64;  // default watchdog limit in cycles

  typedef logic [NDINT-1:-NDFRAC] iir_data_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } seq_state_t;

  // Counter width that can hold the value tmax itself.
  function automatic int wdog_width(input int tmax);
    return $clog2(tmax + 1);
  endfunction

  localparam int WDOG_W = wdog_width(TMAX_DEF);

endpackage

// File: rtl/iir_wdog.sv
// Watchdog: loadable up-counter with clear, enable and terminal-count compare.
// Latency: count updates one cycle after clr/ld/en; tc_o is a same-cycle compare.
// Backpressure: none; the counter holds at terminal count instead of wrapping.
//
// Ports: clk/rst clock and async active-high reset; clr_i zeroes the count;
// ld_i loads ld_val_i; en_i advances by one; tc_o is high while count == tc_val_i.
module iir_wdog import iir_pkg::*; #(
  parameter int W = WDOG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == tc_val_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (ld_i)
      cnt_d = ld_val_i;
    else if (en_i && !tc_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iir_cascade_seq.sv
// Runs each sample through Nsec biquad sections on one shared engine, chaining results.
// Latency: Nsec*(Le+1)+1 cycles from dv_in to dv_out (1 cycle in bypass).
// Backpressure: none; dv_in outside IDLE is dropped and flagged in err_ovr.
//
// Ports: clk/reset (async active-high); dv_in/d_in/bypass sample input;
// clr_err clears sticky flags; dv_out/d_out result; eng_start/eng_sec/eng_x
// drive the engine, eng_done/eng_y return its result; busy = not IDLE;
// err_ovr/err_tmo/err_spur sticky overrun, engine timeout, spurious done.
module iir_cascade_seq import iir_pkg::*; #(
  parameter int Ndint  = NDINT,
  parameter int Ndfrac = NDFRAC,
  parameter int Nsec   = 4,
  parameter int Tmax   = TMAX_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                dv_in,
  input  logic [Ndint-1:-Ndfrac]              d_in,
  input  logic                                bypass,
  input  logic                                clr_err,
  output logic                                dv_out,
  output logic [Ndint-1:-Ndfrac]              d_out,
  output logic                                eng_start,
  output logic [$clog2(Nsec>1?Nsec:2)-1:0]    eng_sec,
  output logic [Ndint-1:-Ndfrac]              eng_x,
  input  logic                                eng_done,
  input  logic [Ndint-1:-Ndfrac]              eng_y,
  output logic                                busy,
  output logic                                err_ovr,
  output logic                                err_tmo,
  output logic                                err_spur
);

  localparam int SW = $clog2(Nsec > 1 ? Nsec : 2);
  localparam int WW = wdog_width(Tmax);

  seq_state_t                 state_q, state_d;
  logic [SW-1:0]              sec_q, sec_d;
  logic [Ndint-1:-Ndfrac]     x_q, x_d;
  logic [Ndint-1:-Ndfrac]     dout_q, dout_d;
  logic                       dv_out_q, dv_out_d;
  logic                       start_q, start_d;
  logic                       busy_q, busy_d;
  logic                       ovr_q, ovr_d;
  logic                       tmo_q, tmo_d;
  logic                       spur_q, spur_d;
  logic                       wd_tc;

  // Loaded with 1 in ISSUE so the count equals the number of WAIT cycles
  // spent so far, including the current one.
  iir_wdog #(.W(WW)) u_wdog (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (state_q == S_IDLE),
    .ld_i     (state_q == S_ISSUE),
    .ld_val_i (WW'(1)),
    .en_i     (state_q == S_WAIT),
    .tc_val_i (WW'(Tmax)),
    .tc_o     (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    x_d     = x_q;
    dout_d  = dout_q;
    // Clear first so that a same-cycle error event below overrides it.
    ovr_d   = ovr_q  & ~clr_err;
    tmo_d   = tmo_q  & ~clr_err;
    spur_d  = spur_q & ~clr_err;

    unique case (state_q)
      S_IDLE: begin
        if (dv_in) begin
          if (bypass) begin
            dout_d  = d_in;
            state_d = S_OUT;
          end else begin
            x_d     = d_in;
            sec_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A done arriving in the expiry cycle still wins over the timeout.
        if (eng_done) begin
          if (sec_q == SW'(Nsec - 1)) begin
            dout_d  = eng_y;
            state_d = S_OUT;
          end else begin
            x_d     = eng_y;
            sec_d   = sec_q + SW'(1);
            state_d = S_ISSUE;
          end
        end else if (wd_tc) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (dv_in && (state_q != S_IDLE))   ovr_d  = 1'b1;
    if (eng_done && (state_q != S_WAIT)) spur_d = 1'b1;

    // Strobes are decoded from the next state so they align with that state.
    start_d  = (state_d == S_ISSUE);
    dv_out_d = (state_d == S_OUT);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sec_q    <= '0;
      x_q      <= '0;
      dout_q   <= '0;
      dv_out_q <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      spur_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      x_q      <= x_d;
      dout_q   <= dout_d;
      dv_out_q <= dv_out_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
      spur_q   <= spur_d;
    end
  end

  assign dv_out    = dv_out_q;
  assign d_out     = dout_q;
  assign eng_start = start_q;
  assign eng_sec   = sec_q;
  assign eng_x     = x_q;
  assign busy      = busy_q;
  assign err_ovr   = ovr_q;
  assign err_tmo   = tmo_q;
  assign err_spur  = spur_q;

endmodule
